// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small decode helpers.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic is_signed_op(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic is_div_op(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_iter_op(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Combinational core of the multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, plus the final sign fixup of HI/LO.
module mdu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] dividend,
    input  logic             neg_q,
    input  logic             neg_r,
    input  logic             div_zero,
    output logic [WIDTH-1:0] step_hi,
    output logic [WIDTH-1:0] step_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] s;
        s = -$signed(x);
        return $unsigned(s);
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] x);
        logic signed [2*WIDTH-1:0] s;
        s = -$signed(x);
        return $unsigned(s);
    endfunction

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   rem_sub;
    logic               ge;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;

    // Multiply keeps {acc_hi, acc_lo} as {partial product, remaining multiplier};
    // divide keeps them as {partial remainder, dividend bits becoming quotient}.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, operand});
        // The restored remainder is always below the divisor, so WIDTH bits suffice.
        rem_sub = shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            step_hi = ge ? rem_sub : shifted[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        product     = {acc_hi, acc_lo};
        product_fix = neg_q ? negate_2w(product) : product;
        if (!is_div) begin
            res_hi = product_fix[2*WIDTH-1:WIDTH];
            res_lo = product_fix[WIDTH-1:0];
        end else if (div_zero) begin
            res_hi = dividend;
            res_lo = '1;
        end else begin
            res_hi = neg_r ? negate_w(acc_hi) : acc_hi;
            res_lo = neg_q ? negate_w(acc_lo) : acc_lo;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; WIDTH steps per operation
// with a separate sign-fixup cycle before results land.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_e       state;
    mdu_op_e          op_r;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand_r;
    logic [WIDTH-1:0] dividend_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             div_zero_r;

    mdu_op_e          op_in;
    logic             sgn_in;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude, so no extra bit is carried.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic is_sgn);
        logic signed [WIDTH-1:0] s;
        s = -$signed(x);
        return (is_sgn && x[WIDTH-1]) ? $unsigned(s) : x;
    endfunction

    always_comb begin
        op_in  = mdu_op_e'(op);
        sgn_in = is_signed_op(op_in);
        mag_a  = magnitude(a, sgn_in);
        mag_b  = magnitude(b, sgn_in);
    end

    mdu_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .is_div   (is_div_op(op_r)),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .operand  (operand_r),
        .dividend (dividend_r),
        .neg_q    (neg_q_r),
        .neg_r    (neg_r_r),
        .div_zero (div_zero_r),
        .step_hi  (step_hi),
        .step_lo  (step_lo),
        .res_hi   (res_hi),
        .res_lo   (res_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_r       <= MDU_MULT;
            count      <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            operand_r  <= '0;
            dividend_r <= '0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (op_in == MDU_MTHI) begin
                            hi <= a;
                        end else if (op_in == MDU_MTLO) begin
                            lo <= a;
                        end else if (is_iter_op(op_in)) begin
                            op_r       <= op_in;
                            acc_hi     <= '0;
                            acc_lo     <= mag_a;
                            operand_r  <= mag_b;
                            dividend_r <= a;
                            neg_q_r    <= sgn_in && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r_r    <= (op_in == MDU_DIV) && a[WIDTH-1];
                            div_zero_r <= (b == '0);
                            count      <= CNT_W'(WIDTH - 1);
                            busy       <= 1'b1;
                            state      <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count - 1'b1;
                    if (count == '0) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_q[$];
    string          name_q[$];

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (busy) begin
                errors++;
                $display("FAIL done_busy_overlap got busy=%0b need busy=0", busy);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got hi=%h lo=%h with nothing pending", hi, lo);
            end else begin
                logic [2*W-1:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({hi, lo} !== e)  begin
                    errors++;
                    $display("FAIL %s got hi=%h lo=%h need hi=%h lo=%h",
                             nm, hi, lo, e[2*W-1:W], e[W-1:0]);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s got %h need %h", nm, got, need);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Issue an iterative op, measure busy length and HI/LO stability while busy.
    task automatic run_op(input string nm, input logic [2:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;
        int  n;
        bit  stable;
        hold_hi = hi;
        hold_lo = lo;
        stable  = 1'b1;
        n       = 0;
        exp_q.push_back({eh, el});
        name_q.push_back(nm);
        issue(o, x, y);
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (hi !== hold_hi || lo !== hold_lo) stable = 1'b0;
            if (n > 200) break;
        end
        check({nm, "_busy_cycles"}, n, 33);
        check({nm, "_hilo_stable"}, {31'd0, stable}, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);

        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg3x4", OP_MULT, 32'hFFFFFFFD, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFF4);
        run_op("mult_minxmin", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("div_neg7by2", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7byneg2", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_by_zero", OP_DIVU, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
        run_op("div_overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mthi_lo", lo, 32'h80000000);
        check("mthi_busy", {31'd0, busy}, 0);
        check("mthi_done", {31'd0, done}, 0);

        issue(OP_MTLO, 32'h0BADF00D, 32'h0);
        check("mtlo_lo", lo, 32'h0BADF00D);
        check("mtlo_hi", hi, 32'hDEADBEEF);

        // MTLO arriving mid-operation must be dropped.
        exp_q.push_back({32'd2, 32'd14});
        name_q.push_back("divu_100by7");
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'h55;
        @(posedge clk);
        #1 start = 1'b0;
        check("mtlo_while_busy_lo", lo, 32'h0BADF00D);
        check("mtlo_while_busy_busy", {31'd0, busy}, 1);
        begin
            int n;
            n = 0;
            while (busy && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("divu_100by7_timeout", {31'd0, busy}, 0);
        end
        @(negedge clk);

        // Reset aborts the multiply with no partial result and no done.
        issue(OP_MULTU, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);
        repeat (40) @(negedge clk);
        run_op("multu_3x5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        repeat (2) @(negedge clk);
        check("pending_results", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
